cache_fill_ctrl: RTL and testbench
==================================

CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 SHALL have parameter NUM_SETS, default 256: number of cache sets.
REQ-002 SHALL have parameter NUM_WAYS, default 8: ways per set, one of 1/2/4/8.
REQ-003 SHALL have parameter TAG_WIDTH, default 20: tag bits per miss.
REQ-004 SHALL have parameter QUEUE_DEPTH, default 4: miss queue entries, power of two, at least 2.
REQ-005 SHALL derive SET_INDEX_WIDTH = $clog2(NUM_SETS) and WAY_INDEX_WIDTH = $clog2(NUM_WAYS).
REQ-006 SHALL have ports, listed as name, direction, width, meaning:
- clk, in, 1: single clock, all state on rising edge.
- reset, in, 1: synchronous, active-low reset.
- miss_valid, in, 1: miss request offered.
- miss_set, in, SET_INDEX_WIDTH: set of the miss.
- miss_tag, in, TAG_WIDTH: tag of the miss.
- miss_ready, out, 1: queue accepts a miss.
- mem_req_valid, out, 1: line fetch request.
- mem_req_set, out, SET_INDEX_WIDTH: fetch set.
- mem_req_tag, out, TAG_WIDTH: fetch tag.
- mem_req_ready, in, 1: memory accepts the request.
- mem_resp_valid, in, 1: fetched line returned, one-cycle pulse.
- lru_fill_en, out, 1: LRU fill lookup strobe.
- lru_fill_set, out, SET_INDEX_WIDTH: LRU lookup set.
- lru_fill_way, in, WAY_INDEX_WIDTH: victim way, valid the cycle after lru_fill_en.
- tag_write_en, out, 1: install strobe.
- tag_write_set, out, SET_INDEX_WIDTH: install set.
- tag_write_way, out, WAY_INDEX_WIDTH: install way.
- tag_write_tag, out, TAG_WIDTH: install tag.
- busy, out, 1: FSM not IDLE or queue not empty.

Function
REQ-007 SHALL hold misses in a FIFO of QUEUE_DEPTH {set,tag} entries. A miss enqueues when miss_valid && miss_ready.
REQ-008 SHALL drive miss_ready = !full, computed from the registered count only. No combinational path from the dequeue to miss_ready.
REQ-009 SHALL allow an enqueue and a dequeue in the same cycle. The count stays unchanged and no entry is lost. The FIFO pointers wrap modulo QUEUE_DEPTH.
REQ-010 SHALL implement the FSM IDLE -> REQ -> WAIT -> LOOKUP -> CAPTURE -> WRITE -> IDLE, with one memory request outstanding at a time.
REQ-011 IDLE: SHALL move to REQ the cycle after the queue becomes non-empty. The FSM stays in IDLE while the queue is empty.
REQ-012 REQ: SHALL assert mem_req_valid with the head set and tag held stable. The FSM moves to WAIT on the cycle mem_req_valid && mem_req_ready.
REQ-013 WAIT: SHALL move to LOOKUP on mem_resp_valid. mem_resp_valid in any other state SHALL be ignored.
REQ-014 LOOKUP: SHALL assert lru_fill_en for exactly one cycle, with lru_fill_set equal to the head set.
REQ-015 CAPTURE: SHALL register lru_fill_way, one cycle after lru_fill_en, into a victim-way register.
REQ-016 WRITE: SHALL assert tag_write_en for exactly one cycle with the head set, the head tag and the victim way. It SHALL dequeue the head in the same cycle.
REQ-017 Latency from mem_resp_valid to tag_write_en SHALL be exactly 3 cycles.
REQ-018 mem_req_valid, lru_fill_en and tag_write_en SHALL be mutually exclusive. Their data outputs SHALL be zero when the matching strobe is low.

Reset
REQ-019 While reset == 0 at a rising edge, the block SHALL clear the FIFO pointers and count, set the FSM to IDLE and zero the victim-way register.
REQ-020 After reset, all outputs SHALL be 0 except miss_ready, which SHALL be 1.
REQ-021 Reset mid-operation SHALL abandon any in-flight request. A later mem_resp_valid SHALL be ignored, and no tag_write_en is issued for the abandoned entry.

Configuration
REQ-022 With macro CACHE_FILL_MERGE_EN defined, a miss whose {set,tag} equals a valid queued entry, including the head, SHALL be accepted (miss_ready unaffected) and merged. No new entry is created.
REQ-023 Without CACHE_FILL_MERGE_EN, every accepted miss SHALL enqueue, and duplicates SHALL produce duplicate fills.
REQ-024 A match against the head in the same cycle that the head dequeues SHALL NOT merge. The miss enqueues as a new entry.

Verification
REQ-025 Single miss: set=0x12, tag=0xABCDE, mem_req_ready=1, mem_resp_valid 4 cycles after the request, lru_fill_way=5 -> one mem_req and one lru_fill_en at set 0x12. tag_write_en follows 3 cycles after the response with set 0x12, way 5, tag 0xABCDE. Then busy=0.
REQ-026 Full queue: 5 back-to-back misses with mem_req_ready=0 -> 4 accepted, miss_ready=0 on the 5th. miss_ready returns to 1 the cycle after the first WRITE.
REQ-027 Simultaneous enqueue and dequeue: full queue, new miss offered in the WRITE cycle -> rejected (miss_ready=0). Offered again the next cycle -> accepted. Tag writes occur in FIFO order.
REQ-028 Reset in WAIT: reset=0 for 1 cycle, then mem_resp_valid pulses -> no lru_fill_en, no tag_write_en, miss_ready=1, busy=0.
REQ-029 Merge, with CACHE_FILL_MERGE_EN defined: two identical misses (set 3, tag 0x7) -> exactly one mem_req and one tag_write. With the macro undefined -> two of each.

Source files
------------

// File: rtl/cache_fill_ctrl.sv
// Cache line-fill controller: queues misses, issues one memory fetch at a time, then installs the tag in the LRU victim way.
// Optional macro CACHE_FILL_MERGE_EN merges a miss that matches an entry already queued.
module cache_fill_ctrl #(
    parameter int NUM_SETS    = 256,
    parameter int NUM_WAYS    = 8,
    parameter int TAG_WIDTH   = 20,
    parameter int QUEUE_DEPTH = 4,
    localparam int SET_INDEX_WIDTH = $clog2(NUM_SETS),
    localparam int WAY_INDEX_WIDTH = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       miss_valid,
    input  logic [SET_INDEX_WIDTH-1:0] miss_set,
    input  logic [TAG_WIDTH-1:0]       miss_tag,
    output logic                       miss_ready,
    output logic                       mem_req_valid,
    output logic [SET_INDEX_WIDTH-1:0] mem_req_set,
    output logic [TAG_WIDTH-1:0]       mem_req_tag,
    input  logic                       mem_req_ready,
    input  logic                       mem_resp_valid,
    output logic                       lru_fill_en,
    output logic [SET_INDEX_WIDTH-1:0] lru_fill_set,
    input  logic [WAY_INDEX_WIDTH-1:0] lru_fill_way,
    output logic                       tag_write_en,
    output logic [SET_INDEX_WIDTH-1:0] tag_write_set,
    output logic [WAY_INDEX_WIDTH-1:0] tag_write_way,
    output logic [TAG_WIDTH-1:0]       tag_write_tag,
    output logic                       busy
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_LOOKUP  = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;
    localparam logic [2:0] S_WRITE   = 3'd5;

    logic [2:0]                 state_q, state_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [WAY_INDEX_WIDTH-1:0] victim_q, victim_d;

    logic [SET_INDEX_WIDTH-1:0] set_mem_q [QUEUE_DEPTH];
    logic [TAG_WIDTH-1:0]       tag_mem_q [QUEUE_DEPTH];

    logic                       full, empty, enq, deq, merge_hit;
    logic [SET_INDEX_WIDTH-1:0] head_set;
    logic [TAG_WIDTH-1:0]       head_tag;

    assign full     = (count_q == CNT_W'(QUEUE_DEPTH));
    assign empty    = (count_q == '0);
    assign deq      = (state_q == S_WRITE);
    assign head_set = set_mem_q[rd_ptr_q];
    assign head_tag = tag_mem_q[rd_ptr_q];

`ifdef CACHE_FILL_MERGE_EN
    // The head is excluded while it retires, otherwise the merged miss would be lost.
    always_comb begin
        merge_hit = 1'b0;
        for (int k = 0; k < QUEUE_DEPTH; k++) begin
            if ((CNT_W'(k) < count_q) && !(k == 0 && deq) &&
                (set_mem_q[rd_ptr_q + PTR_W'(k)] == miss_set) &&
                (tag_mem_q[rd_ptr_q + PTR_W'(k)] == miss_tag)) begin
                merge_hit = 1'b1;
            end
        end
    end
`else
    assign merge_hit = 1'b0;
`endif

    assign enq = miss_valid && !full && !merge_hit;

    always_comb begin
        rd_ptr_d = deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d  = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        victim_d = (state_q == S_CAPTURE) ? lru_fill_way : victim_q;
        case (state_q)
            S_IDLE:    if (!empty) state_d = S_REQ;
            S_REQ:     if (mem_req_ready) state_d = S_WAIT;
            S_WAIT:    if (mem_resp_valid) state_d = S_LOOKUP;
            S_LOOKUP:  state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_WRITE;
            S_WRITE:   state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            victim_q <= victim_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            set_mem_q[wr_ptr_q] <= miss_set;
            tag_mem_q[wr_ptr_q] <= miss_tag;
        end
    end

    assign miss_ready    = !full;
    assign mem_req_valid = (state_q == S_REQ);
    assign mem_req_set   = mem_req_valid ? head_set : '0;
    assign mem_req_tag   = mem_req_valid ? head_tag : '0;
    assign lru_fill_en   = (state_q == S_LOOKUP);
    assign lru_fill_set  = lru_fill_en ? head_set : '0;
    assign tag_write_en  = deq;
    assign tag_write_set = deq ? head_set : '0;
    assign tag_write_way = deq ? victim_q : '0;
    assign tag_write_tag = deq ? head_tag : '0;
    assign busy          = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: directed scenarios plus random traffic checked against a queue-based reference model.
module tb_cache_fill_ctrl;

    localparam int SW = 8;
    localparam int TW = 20;
    localparam int WW = 3;
    localparam int QD = 4;
`ifdef CACHE_FILL_MERGE_EN
    localparam int DUP_FILLS = 1;
`else
    localparam int DUP_FILLS = 2;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          miss_valid = 1'b0;
    logic [SW-1:0] miss_set = '0;
    logic [TW-1:0] miss_tag = '0;
    logic          miss_ready;
    logic          mem_req_valid;
    logic [SW-1:0] mem_req_set;
    logic [TW-1:0] mem_req_tag;
    logic          mem_req_ready = 1'b0;
    logic          mem_resp_valid = 1'b0;
    logic          lru_fill_en;
    logic [SW-1:0] lru_fill_set;
    logic [WW-1:0] lru_fill_way = '0;
    logic          tag_write_en;
    logic [SW-1:0] tag_write_set;
    logic [WW-1:0] tag_write_way;
    logic [TW-1:0] tag_write_tag;
    logic          busy;

    cache_fill_ctrl dut (
        .clk(clk), .reset(reset),
        .miss_valid(miss_valid), .miss_set(miss_set), .miss_tag(miss_tag), .miss_ready(miss_ready),
        .mem_req_valid(mem_req_valid), .mem_req_set(mem_req_set), .mem_req_tag(mem_req_tag),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .lru_fill_en(lru_fill_en), .lru_fill_set(lru_fill_set), .lru_fill_way(lru_fill_way),
        .tag_write_en(tag_write_en), .tag_write_set(tag_write_set), .tag_write_way(tag_write_way),
        .tag_write_tag(tag_write_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SW-1:0] s;
        logic [TW-1:0] t;
    } ent_t;

    int   checks = 0;
    int   errors = 0;
    int   req_cnt = 0, lru_cnt = 0, wr_cnt = 0;
    ent_t mq[$];
    ent_t wr_log[$];
    logic [SW-1:0] exp_sets [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h20};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: pending fills as a plain queue, fill timing as countdowns from the response.
    bit            outstanding = 0;
    bit            lru_prev = 0;
    int            lru_cd = 0, wr_cd = 0;
    logic [WW-1:0] exp_way = '0;

    always @(negedge clk) begin
        bit   exp_lru, exp_wr, acc, merged;
        ent_t h;
        if (!reset) begin
            mq.delete();
            outstanding = 0; lru_prev = 0; lru_cd = 0; wr_cd = 0;
        end else begin
            exp_lru = (lru_cd == 1);
            exp_wr  = (wr_cd == 1);
            if (lru_cd > 0) lru_cd--;
            if (wr_cd > 0) wr_cd--;
            h = '1;
            if (mq.size() > 0) h = mq[0];
            chk("miss_ready", miss_ready, mq.size() < QD);
            chk("lru_fill_en", lru_fill_en, exp_lru);
            chk("tag_write_en", tag_write_en, exp_wr);
            chk("strobe_excl", 64'(mem_req_valid) + 64'(lru_fill_en) + 64'(tag_write_en) <= 1, 1);
            chk("one_outstanding", mem_req_valid && (outstanding || wr_cd != 0 || lru_cd != 0), 0);
            if (!mem_req_valid) chk("req_data_zero", {mem_req_set, mem_req_tag}, 0);
            if (!lru_fill_en)   chk("lru_data_zero", lru_fill_set, 0);
            if (!tag_write_en)  chk("wr_data_zero", {tag_write_set, tag_write_way, tag_write_tag}, 0);
            if (mem_req_valid)  chk("req_head", {mem_req_set, mem_req_tag}, h);
            if (lru_fill_en) begin
                lru_cnt++;
                chk("lru_set", lru_fill_set, h.s);
            end
            if (lru_prev) exp_way = lru_fill_way;
            lru_prev = lru_fill_en;
            if (tag_write_en) begin
                wr_cnt++;
                chk("wr_set_tag", {tag_write_set, tag_write_tag}, h);
                chk("wr_way", tag_write_way, exp_way);
                wr_log.push_back({tag_write_set, tag_write_tag});
            end
            acc = miss_valid && (mq.size() < QD);
            merged = 0;
`ifdef CACHE_FILL_MERGE_EN
            foreach (mq[i])
                if (!(i == 0 && exp_wr) && mq[i].s == miss_set && mq[i].t == miss_tag) merged = 1;
`endif
            if (exp_wr && mq.size() > 0) void'(mq.pop_front());
            if (acc && !merged) mq.push_back({miss_set, miss_tag});
            if (outstanding && mem_resp_valid) begin
                outstanding = 0; lru_cd = 1; wr_cd = 3;
            end
            if (mem_req_valid && mem_req_ready) begin
                req_cnt++;
                outstanding = 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Serves fetches until idle (or until a tag write is presented); spare response pulses must be ignored.
    task automatic drain(input int maxc, input bit stop_on_wr);
        bit done;
        done = 0;
        mem_req_ready = 1'b1;
        for (int c = 0; c < maxc; c++) begin
            if (stop_on_wr ? tag_write_en : !busy) begin
                done = 1;
                break;
            end
            mem_resp_valid = (c % 5 == 4);
            tick(1);
        end
        mem_resp_valid = 1'b0;
        chk(stop_on_wr ? "wait_write" : "drain_idle", done, 1);
    endtask

    task automatic wait_req(input int maxc);
        bit done;
        done = 0;
        for (int c = 0; c < maxc; c++) begin
            if (mem_req_valid) begin
                done = 1;
                break;
            end
            tick(1);
        end
        chk("wait_req", done, 1);
    endtask

    initial begin
        int rb, lb, wb, lg;

        tick(2);
        chk("rst_miss_ready", miss_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {mem_req_valid, lru_fill_en, tag_write_en}, 0);
        chk("rst_data", {mem_req_set, mem_req_tag, lru_fill_set, tag_write_set, tag_write_way, tag_write_tag}, 0);
        reset = 1'b1;
        tick(1);

        // Single miss with exact timing
        rb = req_cnt; lb = lru_cnt; wb = wr_cnt;
        miss_valid = 1'b1; miss_set = 8'h12; miss_tag = 20'hABCDE;
        mem_req_ready = 1'b1; lru_fill_way = 3'd5;
        tick(1);
        miss_valid = 1'b0;
        chk("t1_idle_noreq", mem_req_valid, 0);
        chk("t1_busy", busy, 1);
        tick(1);
        chk("t1_req", mem_req_valid, 1);
        chk("t1_req_data", {mem_req_set, mem_req_tag}, {8'h12, 20'hABCDE});
        tick(4);
        mem_resp_valid = 1'b1;
        tick(1);
        mem_resp_valid = 1'b0;
        chk("t1_lru", {lru_fill_en, lru_fill_set}, {1'b1, 8'h12});
        tick(2);
        chk("t1_write", {tag_write_en, tag_write_set, tag_write_way, tag_write_tag}, {1'b1, 8'h12, 3'd5, 20'hABCDE});
        tick(1);
        chk("t1_idle", busy, 0);
        chk("t1_counts", {8'(req_cnt - rb), 8'(lru_cnt - lb), 8'(wr_cnt - wb)}, {8'd1, 8'd1, 8'd1});

        // Full queue, then a miss offered in the WRITE cycle
        lg = wr_log.size();
        mem_req_ready = 1'b0; lru_fill_way = 3'd3;
        for (int i = 0; i < 5; i++) begin
            miss_valid = 1'b1; miss_set = SW'(i + 1); miss_tag = TW'(i + 'h100);
            chk("full_ready", miss_ready, i < 4);
            tick(1);
        end
        miss_valid = 1'b0;
        drain(100, 1);
        chk("full_first_wr", {tag_write_en, tag_write_set}, {1'b1, 8'h01});
        miss_valid = 1'b1; miss_set = 8'h20; miss_tag = 20'h55;
        chk("wr_cycle_reject", miss_ready, 0);
        tick(1);
        chk("ready_after_write", miss_ready, 1);
        tick(1);
        miss_valid = 1'b0;
        drain(300, 0);
        chk("order_len", wr_log.size() - lg, 5);
        for (int i = 0; i < 5; i++)
            if (lg + i < wr_log.size()) chk("fifo_order", wr_log[lg + i].s, exp_sets[i]);

        // Reset while waiting for the response
        lb = lru_cnt; wb = wr_cnt;
        miss_valid = 1'b1; miss_set = 8'h07; miss_tag = 20'h9;
        mem_req_ready = 1'b1;
        tick(1);
        miss_valid = 1'b0;
        wait_req(20);
        tick(2);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        mem_resp_valid = 1'b1;
        tick(1);
        mem_resp_valid = 1'b0;
        tick(5);
        chk("rst_wait_nofill", {8'(lru_cnt - lb), 8'(wr_cnt - wb)}, 0);
        chk("rst_wait_ready", miss_ready, 1);
        chk("rst_wait_busy", busy, 0);

        // Duplicate misses
        rb = req_cnt; wb = wr_cnt;
        mem_req_ready = 1'b0;
        miss_valid = 1'b1; miss_set = 8'h03; miss_tag = 20'h7;
        tick(2);
        miss_valid = 1'b0;
        drain(200, 0);
        chk("dup_reqs", req_cnt - rb, DUP_FILLS);
        chk("dup_writes", wr_cnt - wb, DUP_FILLS);

        // Head match in its own dequeue cycle must enqueue
        wb = wr_cnt;
        miss_valid = 1'b1;
        tick(1);
        miss_valid = 1'b0;
        drain(100, 1);
        miss_valid = 1'b1;
        chk("head_deq_ready", miss_ready, 1);
        tick(1);
        miss_valid = 1'b0;
        drain(200, 0);
        chk("head_deq_writes", wr_cnt - wb, 2);

        // Random traffic with a narrow set/tag space to provoke duplicates
        for (int c = 0; c < 800; c++) begin
            miss_valid     = ($urandom_range(0, 1) == 1);
            miss_set       = SW'($urandom_range(0, 3));
            miss_tag       = TW'($urandom_range(0, 2));
            mem_req_ready  = ($urandom_range(0, 1) == 1);
            mem_resp_valid = ($urandom_range(0, 3) == 0);
            lru_fill_way   = WW'($urandom_range(0, 7));
            tick(1);
        end
        miss_valid = 1'b0;
        mem_resp_valid = 1'b0;
        drain(400, 0);
        chk("rand_model_empty", mq.size(), 0);
        chk("rand_idle_ready", miss_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
